// File: rtl/child_result_collector.sv
// child_result_collector
// Merges N_CHILD valid/ready result streams into one output stream. A
// round-robin arbiter picks the next child starting from rr_ptr. The winner
// loads a single registered output stage, and each beat is tagged with the
// index of its source child. beat_count counts delivered beats and saturates
// at its maximum value.
module child_result_collector #(
    parameter int N_CHILD = 5,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = $clog2(N_CHILD),
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CHILD-1:0]          in_valid,
    input  logic [N_CHILD*DATA_W-1:0]   in_data,
    output logic [N_CHILD-1:0]          in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            beat_count
);

    logic [IDX_W-1:0]  rr_ptr_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [IDX_W-1:0]  out_idx_r;
    logic [CNT_W-1:0]  beat_count_r;

    logic              can_load_s;
    logic              grant_found_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic [IDX_W-1:0]  next_ptr_s;
    logic [IDX_W:0]    cand_sum_s;
    logic [IDX_W-1:0]  cand_idx_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              in_xfer_s;
    logic              out_xfer_s;

    assign can_load_s = !out_valid_r || out_ready;
    assign out_xfer_s = out_valid_r && out_ready;
    // While reset is held, no source may see ready. Gating with rst_n keeps
    // that true even though the output stage is empty during reset.
    assign in_xfer_s  = grant_found_s && can_load_s && rst_n;

    // Round-robin search: visit rr_ptr, rr_ptr+1, ... modulo N_CHILD and stop at the first valid child
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = '0;
        cand_idx_s    = '0;
        for (int k = 0; k < N_CHILD; k++) begin
            cand_sum_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand_sum_s >= (IDX_W+1)'(N_CHILD)) begin
                cand_sum_s = cand_sum_s - (IDX_W+1)'(N_CHILD);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_idx_s = cand_sum_s[IDX_W-1:0];
            if (!grant_found_s && in_valid[cand_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot ready to the winner, plus selection of its payload and the next priority pointer
    always_comb begin
        in_ready   = '0;
        sel_data_s = in_data[int'(grant_idx_s)*DATA_W +: DATA_W];
        if (in_xfer_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
        if (grant_idx_s == IDX_W'(N_CHILD - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + IDX_W'(1);
        end
    end

    // Output stage and arbitration pointer. A new beat overrides a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_idx_r   <= grant_idx_s;
            rr_ptr_r    <= next_ptr_s;
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Delivered-beat counter that saturates at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_r <= '0;
        end else if (out_xfer_s && (beat_count_r != {CNT_W{1'b1}})) begin
            beat_count_r <= beat_count_r + CNT_W'(1);
        end else begin
            beat_count_r <= beat_count_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_idx    = out_idx_r;
    assign beat_count = beat_count_r;

endmodule

// File: tb/tb_child_result_collector.sv
// Bench for child_result_collector. A directed stimulus process pushes the
// hand-computed beats it expects into a queue. A separate monitor pops from
// that queue and compares every beat accepted downstream.
module tb_child_result_collector;

    localparam int N_CHILD = 5;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 16;

    logic                      clk;
    logic                      rst_n;
    logic [N_CHILD-1:0]        in_valid;
    logic [N_CHILD*DATA_W-1:0] in_data;
    logic [N_CHILD-1:0]        in_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [IDX_W-1:0]          out_idx;
    logic                      out_ready;
    logic [CNT_W-1:0]          beat_count;

    int checks = 0;
    int errors = 0;
    logic [IDX_W+DATA_W-1:0] exp_q[$];

    child_result_collector #(
        .N_CHILD(N_CHILD), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .out_ready(out_ready), .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [7:0] data);
        exp_q.push_back({3'(idx), data});
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N_CHILD; i++) in_data[i*DATA_W +: DATA_W] = 8'h10 + 8'(i);
    endtask

    // Monitor: every beat the downstream accepts must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got idx %0d data %0h, queue empty", out_idx, out_data);
            end else begin
                logic [IDX_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({out_idx, out_data} !== e) begin
                    errors++;
                    $display("FAIL beat: got idx %0d data %0h expected idx %0d data %0h",
                             out_idx, out_data, e[IDX_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single source: child 2 presents A5
        in_data[2*DATA_W +: DATA_W] = 8'hA5;
        in_valid  = 5'b00100;
        out_ready = 1'b1;
        #1;
        check("single_in_ready", 32'(in_ready), 32'b00100);
        push(2, 8'hA5);
        step();
        in_valid = '0;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", 32'(out_data), 32'hA5);
        check("single_out_idx", 32'(out_idx), 32'd2);
        step();
        check("single_beat_count", 32'(beat_count), 32'd1);
        check("single_drained", 32'(out_valid), 32'd0);

        // Async reset during traffic: rr_ptr is 3, so grants are 3 then 4; 4 is discarded
        set_default_data();
        in_valid = 5'b11111;
        push(3, 8'h13);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        check("async_rst_out_idx", 32'(out_idx), 32'd0);
        check("async_rst_beat_count", 32'(beat_count), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);

        // Full-rate round robin after release
        rst_n = 1'b1;
        #1;
        check("first_grant_child0", 32'(in_ready), 32'b00001);
        for (int k = 0; k < 7; k++) push(k % 5, 8'h10 + 8'(k % 5));
        for (int k = 0; k < 7; k++) begin
            step();
            check("fullrate_no_bubble", 32'(out_valid), 32'd1);
            check("fullrate_idx", 32'(out_idx), 32'(k % 5));
        end
        in_valid = '0;
        step();
        check("fullrate_beat_count", 32'(beat_count), 32'd7);
        check("fullrate_drained", 32'(out_valid), 32'd0);

        // Backpressure
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        in_valid = 5'b11111;
        push(0, 8'h10);
        step();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_idx", 32'(out_idx), 32'd0);
            check("bp_out_data", 32'(out_data), 32'h10);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_in_ready", 32'(in_ready), 32'b00010);
        push(1, 8'h11);
        step();
        in_valid = '0;
        step();
        check("bp_beat_count", 32'(beat_count), 32'd2);

        // Wrap and skip: rr_ptr is 2 here; grant child 3 alone, then only 4 and 1 are valid
        in_valid = 5'b01000;
        #1;
        check("wrap_grant3", 32'(in_ready), 32'b01000);
        push(3, 8'h13);
        step();
        in_valid = 5'b10010;
        #1;
        check("wrap_grant4", 32'(in_ready), 32'b10000);
        push(4, 8'h14);
        step();
        in_valid = 5'b00010;
        #1;
        check("wrap_grant1", 32'(in_ready), 32'b00010);
        push(1, 8'h11);
        step();
        in_valid = '0;
        step();
        in_valid = 5'b11111;
        #1;
        check("wrap_rr_ptr2", 32'(in_ready), 32'b00100);
        in_valid = '0;
        #1;

        // Saturation: beat_count must stop at FFFF
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        in_valid = 5'b11111;
        g = 0;
        for (int i = 0; i < 65539; i++) begin
            push(g, 8'h10 + 8'(g));
            step();
            if (i == 65535) check("sat_reach", 32'(beat_count), 32'hFFFF);
            g = (g == 4) ? 0 : g + 1;
        end
        in_valid = '0;
        step();
        check("sat_hold", 32'(beat_count), 32'hFFFF);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/child_result_collector.md
Name: child_result_collector

Overview:
- Fan-in counterpart to the root-level fan-out hierarchy: merges result streams from N_CHILD child instances into one output stream.
- Uses round-robin arbitration with one registered output stage.
- Each output beat is tagged with the index of the child that produced it.
- Sits at the root module boundary; feeds one downstream consumer.

Parameters:
- N_CHILD, 5, number of child input streams (2..16).
- DATA_W, 8, payload width per child.
- IDX_W, $clog2(N_CHILD), width of the child index tag; 3 at default.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- in_valid  input  N_CHILD  per-child valid.
- in_data  input  N_CHILD*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N_CHILD  per-child ready; at most one bit is high per cycle.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output payload.
- out_idx  output  IDX_W  index of the source child.
- out_ready  input  1  downstream ready.
- beat_count  output  CNT_W  number of beats accepted downstream; saturates at all-ones.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - out_valid=0, out_data=0, out_idx=0, beat_count=0.
  - rr_ptr=0, so child 0 has highest priority first.
  - in_ready=0 while rst_n is low.
- Handshake: valid/ready; a transfer occurs when valid&&ready at a rising clk edge.
  - Sources must hold valid and data until accepted.
  - in_valid must not depend on in_ready.
- Output register can load when: can_load = !out_valid || out_ready.
- Arbitration (combinational):
  - grant = first i with in_valid[i] high, searching rr_ptr, rr_ptr+1, ... modulo N_CHILD.
  - in_ready[grant] = can_load; all other in_ready bits are 0.
  - If no in_valid bit is high, in_ready is all 0.
- On an input transfer from child g:
  - out_data <= in_data[g], out_idx <= g, out_valid <= 1.
  - rr_ptr <= (g == N_CHILD-1) ? 0 : g+1. The wrap 4->0 is required at default.
- On an output transfer with no simultaneous input transfer: out_valid <= 0.
- Simultaneous output and input transfer in the same cycle:
  - out_valid stays 1 and the new beat replaces the old one.
  - Sustains full throughput: one beat per cycle.
- rr_ptr changes only on an input transfer; idle cycles do not move priority.
- Latency: an input accepted at edge k appears on out_* immediately after edge k, i.e. one cycle.
- While out_valid=1 and out_ready=0: out_data, out_idx and out_valid are held stable, and every in_ready bit is 0.
- beat_count increments on each out_valid&&out_ready. At 2^CNT_W-1 it holds and does not wrap.
- Asserting rst_n mid-transfer discards the pending output beat. An unaccepted source beat stays with its source.
- Fairness: no child with continuous valid waits more than N_CHILD-1 grants.

Test Plan:
- Reset: rst_n=0 asynchronously during traffic -> out_valid, out_data, out_idx, beat_count and in_ready all 0 with no clock edge; after release the first grant goes to child 0 when all children are valid.
- Single source: child 2 presents 0xA5 with out_ready=1 -> in_ready=5'b00100 that cycle; next cycle out_valid=1, out_data=0xA5, out_idx=2; beat_count=1 after acceptance.
- Full-rate round robin: all 5 children valid continuously (data 0x10+i), out_ready=1 -> out_idx sequence 0,1,2,3,4,0,1 on consecutive cycles with no bubbles; beat_count=7 after 7 beats.
- Backpressure: all children valid, out_ready=0 for 3 cycles after the first beat (idx 0) -> out_data/out_idx held, in_ready=0; when out_ready returns to 1, next beat idx 1 with no beat lost or duplicated.
- Wrap and skip: last grant idx 3 (rr_ptr=4), only children 4 and 1 valid -> grants 4 then 1; rr_ptr ends at 2.
- Saturation: preload by running 65537 accepted beats -> beat_count reads 16'hFFFF and stays there.
